// File: rtl/aes_uart_block_assembler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_uart_pkg
// Purpose  : Shared state encoding, command bytes and error codes for the
//            UART-to-AES block assembler.
// Revision : 1.0
// ============================================================================
package aes_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RX_KEY = 2'd1,
    ST_RX_BLK = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  localparam logic [7:0] CMD_KEY_DEFAULT = 8'h4B;
  localparam logic [7:0] CMD_ENC_DEFAULT = 8'h45;
  localparam logic [7:0] CMD_DEC_DEFAULT = 8'h44;

  localparam logic [1:0] ERR_BAD_CMD = 2'b00;
  localparam logic [1:0] ERR_NO_KEY  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

  localparam int unsigned BLK_BYTES = 16;

endpackage
`default_nettype wire

// File: rtl/aes_uart_block_assembler_timer.sv
`default_nettype none
// ============================================================================
// Module   : uart_idle_timer
// Purpose  : Inter-byte idle counter; expire strobes when the count reaches
//            TIMEOUT_CYCLES-1 while enabled and not being cleared.
// Revision : 1.0
// ============================================================================
module uart_idle_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 104160
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear has priority so a byte arriving on the expiry cycle suppresses it.
  assign expire = en & ~clear & (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en && !expire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/aes_uart_block_assembler.sv
`default_nettype none
// ============================================================================
// Module   : aes_uart_block_assembler
// Purpose  : Frames UART bytes into 'K' key loads and 'E'/'D' AES blocks,
//            presented through a valid/ready handshake with error reporting.
// Revision : 1.0
// ============================================================================
module aes_uart_block_assembler
  import aes_uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 104160,
  parameter logic [7:0]  CMD_KEY        = CMD_KEY_DEFAULT,
  parameter logic [7:0]  CMD_ENC        = CMD_ENC_DEFAULT,
  parameter logic [7:0]  CMD_DEC        = CMD_DEC_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   rx_byte,
  input  logic         rx_ready,
  output logic [127:0] key_out,
  output logic         key_valid,
  output logic [127:0] blk_data,
  output logic         blk_encrypt,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic         err_pulse,
  output logic [1:0]   err_code,
  output logic         busy
);

  localparam logic [3:0] LAST_BYTE = 4'(BLK_BYTES - 1);

  state_e         state_q, state_d;
  logic [127:0]   sr_q, sr_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [127:0]   key_q, key_d;
  logic           key_valid_q, key_valid_d;
  logic [127:0]   blk_q, blk_d;
  logic           blk_enc_q, blk_enc_d;
  logic           blk_valid_q, blk_valid_d;
  logic           mode_enc_q, mode_enc_d;
  logic           err_pulse_q, err_pulse_d;
  logic [1:0]     err_code_q, err_code_d;

  logic           in_rx;
  logic           tmr_clear;
  logic           tmr_expire;
  logic [127:0]   sr_shift;

  assign in_rx     = (state_q == ST_RX_KEY) || (state_q == ST_RX_BLK);
  assign tmr_clear = !in_rx || rx_ready;
  assign sr_shift  = {sr_q[119:0], rx_byte};

  uart_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (tmr_clear),
    .en    (in_rx),
    .expire(tmr_expire)
  );

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    blk_d       = blk_q;
    blk_enc_d   = blk_enc_q;
    blk_valid_d = blk_valid_q;
    mode_enc_d  = mode_enc_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;

    case (state_q)
      ST_IDLE: begin
        if (rx_ready) begin
          cnt_d = '0;
          if (rx_byte == CMD_KEY) begin
            state_d = ST_RX_KEY;
          end else if (rx_byte == CMD_ENC || rx_byte == CMD_DEC) begin
            if (key_valid_q) begin
              state_d    = ST_RX_BLK;
              mode_enc_d = (rx_byte == CMD_ENC);
            end else begin
              err_pulse_d = 1'b1;
              err_code_d  = ERR_NO_KEY;
            end
          end else begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_BAD_CMD;
          end
        end
      end

      ST_RX_KEY, ST_RX_BLK: begin
        if (rx_ready) begin
          sr_d  = sr_shift;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LAST_BYTE) begin
            if (state_q == ST_RX_KEY) begin
              key_d       = sr_shift;
              key_valid_d = 1'b1;
              state_d     = ST_IDLE;
            end else begin
              blk_d       = sr_shift;
              blk_enc_d   = mode_enc_q;
              blk_valid_d = 1'b1;
              state_d     = ST_HOLD;
            end
          end
        end else if (tmr_expire) begin
          // Partial payload is abandoned; key_out is only written on completion.
          state_d     = ST_IDLE;
          cnt_d       = '0;
          err_pulse_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
        end
      end

      ST_HOLD: begin
        if (rx_ready) begin
          err_pulse_d = 1'b1;
          err_code_d  = ERR_OVERRUN;
        end
        if (blk_ready) begin
          blk_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      blk_q       <= '0;
      blk_enc_q   <= 1'b0;
      blk_valid_q <= 1'b0;
      mode_enc_q  <= 1'b0;
      err_pulse_q <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      blk_q       <= blk_d;
      blk_enc_q   <= blk_enc_d;
      blk_valid_q <= blk_valid_d;
      mode_enc_q  <= mode_enc_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
    end
  end

  assign key_out     = key_q;
  assign key_valid   = key_valid_q;
  assign blk_data    = blk_q;
  assign blk_encrypt = blk_enc_q;
  assign blk_valid   = blk_valid_q;
  assign err_pulse   = err_pulse_q;
  assign err_code    = err_code_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aes_uart_block_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_uart_block_assembler
// Purpose  : Directed bench with a byte-level framing model compared against
//            the assembler every cycle, plus literal spot checks.
// Revision : 1.0
// ============================================================================
module tb_aes_uart_block_assembler;

  localparam int unsigned TO = 200;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   rx_byte = 8'h00;
  logic         rx_ready = 1'b0;
  logic         blk_ready = 1'b0;
  logic [127:0] key_out, blk_data;
  logic         key_valid, blk_encrypt, blk_valid, err_pulse, busy;
  logic [1:0]   err_code;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_uart_block_assembler #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_ready(rx_ready),
    .key_out(key_out), .key_valid(key_valid), .blk_data(blk_data),
    .blk_encrypt(blk_encrypt), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .err_pulse(err_pulse), .err_code(err_code), .busy(busy)
  );

  // ---------------- behavioural model ----------------
  logic [7:0]   m_bytes [16];
  int           m_n, m_idle;
  bit           m_collect, m_is_key, m_hold, m_mode_enc;
  logic [127:0] m_key, m_blk;
  bit           m_key_valid, m_enc, m_blk_valid, m_err_pulse;
  logic [1:0]   m_err_code;

  function automatic logic [127:0] pack_payload(input logic [7:0] last);
    logic [127:0] w;
    w = '0;
    for (int i = 0; i < 15; i++) w[127-8*i -: 8] = m_bytes[i];
    w[7:0] = last;
    return w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n <= 0; m_idle <= 0; m_collect <= 0; m_is_key <= 0; m_hold <= 0;
      m_mode_enc <= 0; m_key <= '0; m_blk <= '0; m_key_valid <= 0; m_enc <= 0;
      m_blk_valid <= 0; m_err_pulse <= 0; m_err_code <= 2'b00;
    end else begin
      m_err_pulse <= 0;
      if (m_hold) begin
        if (rx_ready) begin m_err_pulse <= 1; m_err_code <= 2'b11; end
        if (blk_ready) begin m_hold <= 0; m_blk_valid <= 0; end
      end else if (m_collect) begin
        if (rx_ready) begin
          m_bytes[m_n] <= rx_byte;
          m_idle <= 0;
          if (m_n == 15) begin
            m_collect <= 0;
            m_n <= 0;
            if (m_is_key) begin
              m_key <= pack_payload(rx_byte); m_key_valid <= 1;
            end else begin
              m_blk <= pack_payload(rx_byte); m_enc <= m_mode_enc;
              m_blk_valid <= 1; m_hold <= 1;
            end
          end else begin
            m_n <= m_n + 1;
          end
        end else if (m_idle == TO - 1) begin
          m_collect <= 0; m_n <= 0; m_err_pulse <= 1; m_err_code <= 2'b10;
        end else begin
          m_idle <= m_idle + 1;
        end
      end else if (rx_ready) begin
        m_idle <= 0;
        m_n <= 0;
        if (rx_byte == 8'h4B) begin
          m_collect <= 1; m_is_key <= 1;
        end else if (rx_byte == 8'h45 || rx_byte == 8'h44) begin
          if (m_key_valid) begin
            m_collect <= 1; m_is_key <= 0; m_mode_enc <= (rx_byte == 8'h45);
          end else begin
            m_err_pulse <= 1; m_err_code <= 2'b01;
          end
        end else begin
          m_err_pulse <= 1; m_err_code <= 2'b00;
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cmp_key_out",   key_out,           m_key);
    check("cmp_key_valid", 128'(key_valid),   128'(m_key_valid));
    check("cmp_blk_data",  blk_data,          m_blk);
    check("cmp_blk_enc",   128'(blk_encrypt), 128'(m_enc));
    check("cmp_blk_valid", 128'(blk_valid),   128'(m_blk_valid));
    check("cmp_err_pulse", 128'(err_pulse),   128'(m_err_pulse));
    check("cmp_err_code",  128'(err_code),    128'(m_err_code));
    check("cmp_busy",      128'(busy),        128'(m_collect | m_hold));
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_byte = b; rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] base, input logic [7:0] step);
    send(cmd);
    for (int i = 0; i < 16; i++) send(base + 8'(i) * step);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] key1, blk1;
    key1 = 128'h000102030405060708090A0B0C0D0E0F;
    blk1 = 128'h00112233445566778899AABBCCDDEEFF;

    idle(3);
    check("reset_key_valid", 128'(key_valid), 128'd0);
    check("reset_busy",      128'(busy),      128'd0);
    #2 rst_n = 1'b1;
    idle(2);

    // Test 2: block command with no key, then non-command bytes
    send(8'h45);
    check("nokey_pulse", 128'(err_pulse), 128'd1);
    check("nokey_code",  128'(err_code),  128'd1);
    check("nokey_busy",  128'(busy),      128'd0);
    for (int i = 0; i < 16; i++) begin
      send(8'(i));
      check("badcmd_pulse", 128'(err_pulse), 128'd1);
      check("badcmd_code",  128'(err_code),  128'd0);
    end

    // Test 1: key load then encrypt block
    send_frame(8'h4B, 8'h00, 8'h01);
    check("t1_key",       key_out,           key1);
    check("t1_key_valid", 128'(key_valid),   128'd1);
    send_frame(8'h45, 8'h00, 8'h11);
    check("t1_blk_valid", 128'(blk_valid),   128'd1);
    check("t1_blk_data",  blk_data,          blk1);
    check("t1_blk_enc",   128'(blk_encrypt), 128'd1);
    blk_ready = 1'b1;
    idle(1);
    blk_ready = 1'b0;
    check("t1_released",  128'(blk_valid),   128'd0);

    // Test 3: partial key then timeout
    send(8'h4B);
    for (int i = 0; i < 5; i++) send(8'hF0 + 8'(i));
    idle(TO - 1);
    check("t3_no_early_err", 128'(err_pulse), 128'd0);
    check("t3_busy_before",  128'(busy),      128'd1);
    idle(1);
    check("t3_to_pulse",  128'(err_pulse), 128'd1);
    check("t3_to_code",   128'(err_code),  128'd2);
    check("t3_busy_after",128'(busy),      128'd0);
    check("t3_key_kept",  key_out,         key1);
    send_frame(8'h4B, 8'h10, 8'h01);
    check("t3_new_key", key_out, 128'h101112131415161718191A1B1C1D1E1F);

    // Test 4: held block, overrun byte, then handshake
    send_frame(8'h45, 8'hA0, 8'h01);
    idle(50);
    check("t4_valid_held", 128'(blk_valid), 128'd1);
    send(8'h41);
    check("t4_ovr_pulse", 128'(err_pulse), 128'd1);
    check("t4_ovr_code",  128'(err_code),  128'd3);
    check("t4_blk_same",  blk_data, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
    blk_ready = 1'b1;
    idle(1);
    check("t4_valid_drop", 128'(blk_valid), 128'd0);
    check("t4_busy_drop",  128'(busy),      128'd0);

    // Test 5: decrypt with blk_ready tied high
    send_frame(8'h44, 8'h30, 8'h02);
    check("t5_valid",   128'(blk_valid),   128'd1);
    check("t5_dec",     128'(blk_encrypt), 128'd0);
    check("t5_data",    blk_data, 128'h30323436383A3C3E40424446484A4C4E);
    idle(1);
    check("t5_one_cyc", 128'(blk_valid),   128'd0);
    blk_ready = 1'b0;

    // Test 6: asynchronous reset mid key frame
    send(8'h4B);
    for (int i = 0; i < 8; i++) send(8'h55);
    #3 rst_n = 1'b0;
    #1;
    check("t6_key_out",   key_out,          128'd0);
    check("t6_key_valid", 128'(key_valid),  128'd0);
    check("t6_blk_data",  blk_data,         128'd0);
    check("t6_busy",      128'(busy),       128'd0);
    check("t6_err_code",  128'(err_code),   128'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send_frame(8'h4B, 8'h01, 8'h03);
    check("t6_reload", key_out, 128'h0104070A0D101316191C1F2225282B2E);
    check("t6_reload_valid", 128'(key_valid), 128'd1);

    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
